imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the byte-address width of the target instruction memory.
REQ-002 The block SHALL have port i_clk  input  1  rising-edge clock; the block's only clock.
REQ-003 The block SHALL have port i_rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have port i_start  input  1  single-cycle load request, sampled only in IDLE.
REQ-005 The block SHALL have port i_base_addr  input  ADDR_W  first byte address of the image.
REQ-006 The block SHALL have port i_len  input  ADDR_W+1  image length in bytes, 0..2^ADDR_W.
REQ-007 The block SHALL have port i_abort  input  1  cancels a load in progress.
REQ-008 The block SHALL have ports i_byte_valid  input  1  and i_byte_data  input  8, carrying the image byte stream.
REQ-009 The block SHALL have port o_byte_ready  output  1  stream byte accept.
REQ-010 The block SHALL have ports o_mem_we  output  1 ; o_mem_addr  output  ADDR_W ; o_mem_wdata  output  32 ; o_mem_be  output  4, forming the word write port into the instruction memory.
REQ-011 The block SHALL have ports o_busy  output  1 ; o_done  output  1 ; o_err  output  1 ; o_checksum  output  8, reporting status.

Function
REQ-012 The block SHALL implement states IDLE, RECV, WRITE and DONE.
REQ-013 In IDLE, when i_start=1, the block SHALL check the request: i_base_addr[1:0]!=0, or i_base_addr+i_len>2^ADDR_W, SHALL pulse o_err for 1 cycle and remain in IDLE.
REQ-014 For a valid request with i_len=0, the block SHALL go to DONE with no memory write.
REQ-015 For a valid request with i_len>0, the block SHALL latch base and length, clear the byte count, lane index and checksum, and go to RECV.
REQ-016 o_byte_ready SHALL be 1 only in RECV, and a byte SHALL be accepted on a cycle with i_byte_valid & o_byte_ready.
REQ-017 Accepted bytes SHALL be packed little-endian: byte k of a word SHALL go to wdata[8k+7:8k] and set be[k].
REQ-018 Each accepted byte SHALL be added to o_checksum modulo 256.
REQ-019 On acceptance of lane 3, or of the final byte of the image, the block SHALL go to WRITE.
REQ-020 In WRITE, for exactly 1 cycle, o_mem_we SHALL be 1, with o_mem_addr = base + 4*word index, and o_mem_wdata/o_mem_be holding the packed word; unused lanes SHALL have be=0 and wdata=0.
REQ-021 Write timing: the byte accepted at cycle N SHALL produce o_mem_we at N+1, and RECV SHALL resume at N+2 (o_byte_ready=0 during WRITE).
REQ-022 After the write of the final word, the block SHALL go to DONE; DONE SHALL pulse o_done for 1 cycle and then return to IDLE.
REQ-023 o_checksum SHALL hold its value in IDLE until the next valid start.
REQ-024 o_busy SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-025 i_start outside IDLE SHALL be ignored.
REQ-026 i_abort in RECV or WRITE SHALL suppress any pending write (o_mem_we=0 that cycle), discard the partial word, pulse o_err, and return to IDLE; i_abort SHALL take priority over a simultaneous byte acceptance.
REQ-027 i_abort in IDLE or DONE SHALL have no effect.
REQ-028 o_mem_we, o_mem_addr, o_mem_wdata and o_mem_be SHALL be driven from registers, never combinationally from the stream inputs; o_mem_addr SHALL not wrap, because overflow is rejected at start.

Reset
REQ-029 While i_rst=1 at a clock edge, the block SHALL enter IDLE and set o_byte_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_busy, o_done, o_err and o_checksum to 0.
REQ-030 Reset mid-load SHALL abandon the load with no further writes, no o_done and no o_err.

Verification
REQ-031 Base 0x0000, len 8, bytes 13 00 00 00 93 00 10 00 -> writes (0x0000, 0x00000013, be F) and (0x0004, 0x00100093, be F); o_done 1 cycle; checksum 0xB6.
REQ-032 Base 0x0100, len 6, bytes 01..06 -> writes (0x0100, 0x04030201, F) and (0x0104, 0x00000605, be 3); o_done asserted.
REQ-033 Base 0x0002 -> o_err 1 cycle with no write; base 0xFFFC with len 8 -> o_err with no write; len 0 at 0x0000 -> o_done with no write.
REQ-034 i_byte_valid held 1 -> o_byte_ready pattern 1,1,1,1,0 per word; a write SHALL follow the 4th byte by exactly 1 cycle.
REQ-035 Abort asserted after 5 of 8 bytes -> exactly 1 write (word 0), o_err pulse, IDLE; i_rst after 3 bytes -> all outputs 0 with no write.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives an instruction image as a byte stream, packs it
// little-endian into 32-bit words, and writes each word into instruction
// memory. Status outputs report busy, done, error and a running checksum.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_abort,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [7:0]        o_checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One past the last addressable byte; a request may end exactly here.
  localparam logic [ADDR_W+1:0] ADDR_LIMIT = {2'b01, {ADDR_W{1'b0}}};

  state_e state_q, state_d;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   byteCount_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [7:0]        checksum_q;
  logic              err_q;

  logic [ADDR_W+1:0] reqEnd;
  logic              reqBad;
  logic              reqEmpty;
  logic              accept;
  logic [ADDR_W:0]   countInc;
  logic              lastByte;
  logic              wordFull;
  logic              allSent;

  assign reqEnd   = {2'b00, i_base_addr} + {1'b0, i_len};
  assign reqBad   = (i_base_addr[1:0] != 2'b00) || (reqEnd > ADDR_LIMIT);
  assign reqEmpty = (i_len == '0);
  // Abort wins over a byte offered in the same cycle, so such a byte is never taken.
  assign accept   = (state_q == RECV) && i_byte_valid && !i_abort;
  assign countInc = byteCount_q + (ADDR_W+1)'(1);
  assign lastByte = (countInc == len_q);
  assign wordFull = (lane_q == 2'd3);
  assign allSent  = (byteCount_q == len_q);

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection: start checks, word completion, final word and abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start && !reqBad) begin
          state_d = reqEmpty ? DONE : RECV;
        end
      end
      RECV: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (accept && (wordFull || lastByte)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          state_d = allSent ? DONE : RECV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status and handshake outputs decoded from the current state; an abort in WRITE squashes the write.
  always_comb begin
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (state_q)
      IDLE:    o_busy       = 1'b0;
      RECV:    o_byte_ready = 1'b1;
      WRITE:   o_mem_we     = !i_abort;
      DONE:    o_done       = 1'b1;
      default: o_busy       = 1'b0;
    endcase
  end

  // Datapath: latch the request, pack bytes into the word, advance the address after each write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q       <= '0;
      byteCount_q <= '0;
      lane_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'h0;
      checksum_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (reqBad) begin
              err_q <= 1'b1;
            end else begin
              len_q       <= i_len;
              byteCount_q <= '0;
              lane_q      <= 2'd0;
              addr_q      <= i_base_addr;
              wdata_q     <= '0;
              be_q        <= 4'h0;
              checksum_q  <= 8'h00;
            end
          end
        end
        RECV: begin
          if (i_abort) begin
            err_q   <= 1'b1;
            wdata_q <= '0;
            be_q    <= 4'h0;
          end else if (accept) begin
            wdata_q[{lane_q, 3'b000} +: 8] <= i_byte_data;
            be_q[lane_q]                   <= 1'b1;
            checksum_q                     <= checksum_q + i_byte_data;
            byteCount_q                    <= countInc;
            lane_q                         <= lane_q + 2'd1;
          end
        end
        WRITE: begin
          wdata_q <= '0;
          be_q    <= 4'h0;
          lane_q  <= 2'd0;
          if (i_abort) begin
            err_q <= 1'b1;
          end else if (!allSent) begin
            addr_q <= addr_q + ADDR_W'(4);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;
  assign o_err       = err_q;
  assign o_checksum  = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven image loads plus hand-written abort, reset
// and handshake-timing sequences; memory writes are checked against a
// queue of expected words.
module tb_imem_loader;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_base_addr;
  logic [16:0] i_len;
  logic        i_abort;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_checksum;

  imem_loader #(.ADDR_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_len        (i_len),
    .i_abort      (i_abort),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_checksum   (o_checksum)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct packed {
    logic [15:0] base;
    logic [16:0] len;
    logic [63:0] bytes;
    logic        expErr;
    logic        expDone;
    logic [1:0]  nw;
    logic [15:0] w0Addr;
    logic [31:0] w0Data;
    logic [3:0]  w0Be;
    logic [15:0] w1Addr;
    logic [31:0] w1Data;
    logic [3:0]  w1Be;
    logic        chkCk;
    logic [7:0]  expCk;
  } vec_t;

  wr_t  expQ[$];
  vec_t vecs[8];
  int   vectors;
  int   miscompares;
  int   doneSeen;
  int   errSeen;
  int   writesSeen;

  // Free-running clock, 10 time units per cycle.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Mid-cycle monitor: counts status pulses and checks each write against the expected-write queue.
  initial begin
    wr_t got;
    wr_t exp;
    doneSeen   = 0;
    errSeen    = 0;
    writesSeen = 0;
    forever begin
      @(negedge i_clk);
      if (o_done === 1'b1) doneSeen++;
      if (o_err === 1'b1) errSeen++;
      if (o_mem_we === 1'b1) begin
        writesSeen++;
        vectors++;
        got = '{addr: o_mem_addr, data: o_mem_wdata, be: o_mem_be};
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpectedWrite: got addr=%h data=%h be=%h, required no write",
                   got.addr, got.data, got.be);
        end else begin
          exp = expQ.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL memWrite: got addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                     got.addr, got.data, got.be, exp.addr, exp.data, exp.be);
          end
        end
      end
    end
  end

  function automatic vec_t mkVec(input logic [15:0] base, input logic [16:0] len,
                                 input logic [63:0] bytes, input logic expErr,
                                 input logic expDone, input logic [1:0] nw,
                                 input logic [15:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                                 input logic [15:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                                 input logic chkCk, input logic [7:0] expCk);
    vec_t v;
    v.base = base;  v.len = len;  v.bytes = bytes;
    v.expErr = expErr;  v.expDone = expDone;  v.nw = nw;
    v.w0Addr = a0;  v.w0Data = d0;  v.w0Be = b0;
    v.w1Addr = a1;  v.w1Data = d1;  v.w1Be = b1;
    v.chkCk = chkCk;  v.expCk = expCk;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ready"},  32'(o_byte_ready), 32'd0);
    checkOutput({tag, ".we"},     32'(o_mem_we),     32'd0);
    checkOutput({tag, ".addr"},   32'(o_mem_addr),   32'd0);
    checkOutput({tag, ".wdata"},  o_mem_wdata,       32'd0);
    checkOutput({tag, ".be"},     32'(o_mem_be),     32'd0);
    checkOutput({tag, ".busy"},   32'(o_busy),       32'd0);
    checkOutput({tag, ".done"},   32'(o_done),       32'd0);
    checkOutput({tag, ".err"},    32'(o_err),        32'd0);
    checkOutput({tag, ".cksum"},  32'(o_checksum),   32'd0);
  endtask

  task automatic startLoad(input logic [15:0] base, input logic [16:0] len);
    @(posedge i_clk);
    #1;
    i_start     = 1'b1;
    i_base_addr = base;
    i_len       = len;
    tick();
    i_start = 1'b0;
  endtask

  // Offer bytes continuously, advancing only when the DUT is ready; bounded by a cycle budget.
  task automatic streamBytes(input logic [63:0] bytes, input int count, input string tag);
    int idx = 0;
    int guard = 0;
    while (idx < count && guard < 200) begin
      i_byte_valid = 1'b1;
      i_byte_data  = bytes[idx*8 +: 8];
      if (o_byte_ready === 1'b1) idx++;
      tick();
      guard++;
    end
    i_byte_valid = 1'b0;
    checkOutput({tag, ".bytesTaken"}, 32'(idx), 32'(count));
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    int d0 = doneSeen;
    int e0 = errSeen;
    int w0 = writesSeen;
    string tag;
    tag = $sformatf("vec%0d", n);
    if (v.nw > 0) expQ.push_back('{addr: v.w0Addr, data: v.w0Data, be: v.w0Be});
    if (v.nw > 1) expQ.push_back('{addr: v.w1Addr, data: v.w1Data, be: v.w1Be});
    startLoad(v.base, v.len);
    if (!v.expErr && v.len != 0) streamBytes(v.bytes, int'(v.len), tag);
    repeat (6) tick();
    checkOutput({tag, ".done"},   32'(doneSeen - d0),   32'(v.expDone));
    checkOutput({tag, ".err"},    32'(errSeen - e0),    32'(v.expErr));
    checkOutput({tag, ".writes"}, 32'(writesSeen - w0), 32'(v.nw));
    checkOutput({tag, ".qLeft"},  32'(expQ.size()),     32'd0);
    checkOutput({tag, ".busy"},   32'(o_busy),          32'd0);
    if (v.chkCk) checkOutput({tag, ".cksum"}, 32'(o_checksum), 32'(v.expCk));
  endtask

  // Main sequence: reset, vector table, then multi-cycle corner cases.
  initial begin
    int d0;
    int e0;
    int w0;
    int accepted;
    logic [9:0] expReady;
    logic [9:0] expWe;
    vectors      = 0;
    miscompares  = 0;
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_base_addr  = '0;
    i_len        = '0;
    i_abort      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_data  = 8'h00;

    vecs[0] = mkVec(16'h0000, 17'd8, 64'h00100093_00000013, 1'b0, 1'b1, 2'd2,
                    16'h0000, 32'h00000013, 4'hF, 16'h0004, 32'h00100093, 4'hF, 1'b1, 8'hB6);
    vecs[1] = mkVec(16'h0100, 17'd6, 64'h00000605_04030201, 1'b0, 1'b1, 2'd2,
                    16'h0100, 32'h04030201, 4'hF, 16'h0104, 32'h00000605, 4'h3, 1'b1, 8'h15);
    vecs[2] = mkVec(16'h0002, 17'd4, 64'h0, 1'b1, 1'b0, 2'd0,
                    16'h0, 32'h0, 4'h0, 16'h0, 32'h0, 4'h0, 1'b1, 8'h15);
    vecs[3] = mkVec(16'hFFFC, 17'd8, 64'h0, 1'b1, 1'b0, 2'd0,
                    16'h0, 32'h0, 4'h0, 16'h0, 32'h0, 4'h0, 1'b1, 8'h15);
    vecs[4] = mkVec(16'hFFFC, 17'd4, 64'h00000000_DDCCBBAA, 1'b0, 1'b1, 2'd1,
                    16'hFFFC, 32'hDDCCBBAA, 4'hF, 16'h0, 32'h0, 4'h0, 1'b1, 8'h0E);
    vecs[5] = mkVec(16'h0000, 17'd0, 64'h0, 1'b0, 1'b1, 2'd0,
                    16'h0, 32'h0, 4'h0, 16'h0, 32'h0, 4'h0, 1'b0, 8'h00);
    vecs[6] = mkVec(16'h0010, 17'd1, 64'h7F, 1'b0, 1'b1, 2'd1,
                    16'h0010, 32'h0000007F, 4'h1, 16'h0, 32'h0, 4'h0, 1'b1, 8'h7F);
    vecs[7] = mkVec(16'h0020, 17'd3, 64'hA09080, 1'b0, 1'b1, 2'd1,
                    16'h0020, 32'h00A09080, 4'h7, 16'h0, 32'h0, 4'h0, 1'b1, 8'hB0);

    repeat (3) tick();
    checkAllZero("reset");
    i_rst = 1'b0;
    tick();

    for (int n = 0; n < 8; n++) begin
      applyStimulus(vecs[n], n);
    end

    // Handshake timing: ready pattern 1111 0 per word, write one cycle after the 4th byte,
    // a stray start while busy is ignored, and an abort in DONE does nothing.
    $display("[TB] ready/write timing sequence");
    expQ.push_back('{addr: 16'h0200, data: 32'h03020100, be: 4'hF});
    expQ.push_back('{addr: 16'h0204, data: 32'h07060504, be: 4'hF});
    d0 = doneSeen; e0 = errSeen; w0 = writesSeen;
    startLoad(16'h0200, 17'd8);
    expReady = 10'b0111101111;
    expWe    = 10'b1000010000;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      i_byte_valid = 1'b1;
      i_byte_data  = 8'(accepted);
      i_start      = (i == 2);
      i_base_addr  = 16'h0002;
      i_len        = 17'd1;
      checkOutput($sformatf("timing.ready%0d", i), 32'(o_byte_ready), 32'(expReady[i]));
      checkOutput($sformatf("timing.we%0d", i),    32'(o_mem_we),     32'(expWe[i]));
      if (o_byte_ready === 1'b1) accepted++;
      tick();
    end
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    i_abort      = 1'b1;
    checkOutput("timing.doneNow", 32'(o_done), 32'd1);
    checkOutput("timing.busyDone", 32'(o_busy), 32'd1);
    tick();
    i_abort = 1'b0;
    checkOutput("timing.busyIdle", 32'(o_busy), 32'd0);
    repeat (4) tick();
    checkOutput("timing.done",   32'(doneSeen - d0),   32'd1);
    checkOutput("timing.err",    32'(errSeen - e0),    32'd0);
    checkOutput("timing.writes", 32'(writesSeen - w0), 32'd2);
    checkOutput("timing.cksum",  32'(o_checksum),      32'h1C);

    // Abort after 5 of 8 bytes, with a byte offered in the abort cycle: only word 0 is written.
    $display("[TB] abort after five bytes");
    expQ.push_back('{addr: 16'h0300, data: 32'h14131211, be: 4'hF});
    d0 = doneSeen; e0 = errSeen; w0 = writesSeen;
    startLoad(16'h0300, 17'd8);
    streamBytes(64'h18171615_14131211, 5, "abort5");
    i_byte_valid = 1'b1;
    i_byte_data  = 8'h16;
    i_abort      = 1'b1;
    tick();
    i_abort      = 1'b0;
    i_byte_valid = 1'b0;
    checkOutput("abort5.readyOff", 32'(o_byte_ready), 32'd0);
    checkOutput("abort5.errNow",   32'(o_err),        32'd1);
    repeat (6) tick();
    checkOutput("abort5.done",   32'(doneSeen - d0),   32'd0);
    checkOutput("abort5.err",    32'(errSeen - e0),    32'd1);
    checkOutput("abort5.writes", 32'(writesSeen - w0), 32'd1);
    checkOutput("abort5.busy",   32'(o_busy),          32'd0);

    // Abort coinciding with the 4th byte of a word: abort wins, no write at all.
    $display("[TB] abort on word-completing byte");
    d0 = doneSeen; e0 = errSeen; w0 = writesSeen;
    startLoad(16'h0400, 17'd4);
    streamBytes(64'h44332211, 3, "abortLane3");
    i_byte_valid = 1'b1;
    i_byte_data  = 8'h44;
    i_abort      = 1'b1;
    tick();
    i_abort      = 1'b0;
    i_byte_valid = 1'b0;
    repeat (6) tick();
    checkOutput("abortLane3.err",    32'(errSeen - e0),    32'd1);
    checkOutput("abortLane3.done",   32'(doneSeen - d0),   32'd0);
    checkOutput("abortLane3.writes", 32'(writesSeen - w0), 32'd0);

    // Reset after 3 bytes: everything returns to zero, no write, no done, no err afterwards.
    $display("[TB] reset mid-load");
    startLoad(16'h0500, 17'd8);
    streamBytes(64'h28272625_24232221, 3, "rstMid");
    d0 = doneSeen; e0 = errSeen; w0 = writesSeen;
    i_rst = 1'b1;
    tick();
    checkAllZero("rstMid");
    i_rst = 1'b0;
    repeat (6) tick();
    checkOutput("rstMid.done",   32'(doneSeen - d0),   32'd0);
    checkOutput("rstMid.err",    32'(errSeen - e0),    32'd0);
    checkOutput("rstMid.writes", 32'(writesSeen - w0), 32'd0);
    checkOutput("rstMid.qLeft",  32'(expQ.size()),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
